// File: rtl/cam_pkg.sv
`default_nettype none
// ============================================================================
//  cam_pkg
//  Shared types and helpers for the CAM match path.
//  Revision: 1.0
// ============================================================================
package cam_pkg;

    localparam string PRIO_LOW  = "LOW";
    localparam string PRIO_HIGH = "HIGH";

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WALK = 1'b1;

    typedef enum logic [0:0] {
        IDLE = ST_IDLE,
        WALK = ST_WALK
    } walk_state_e;

    // $clog2 collapses to 0 for a single entry; an index still needs one bit.
    function automatic int idx_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/match_prio_enc.sv
`default_nettype none
// ============================================================================
//  match_prio_enc
//  Combinational priority encoder: index and one-hot of the winning set bit.
//  Revision: 1.0
// ============================================================================
module match_prio_enc
    import cam_pkg::*;
#(
    parameter int    WIDTH        = 8,
    parameter string LSB_PRIORITY = PRIO_LOW,
    parameter int    IDX_W        = idx_width(WIDTH)
) (
    input  logic [WIDTH-1:0] pending,
    output logic             valid,
    output logic [IDX_W-1:0] index,
    output logic [WIDTH-1:0] onehot
);

    logic [IDX_W-1:0] w_idx;

    if (LSB_PRIORITY == PRIO_HIGH) begin : g_lowest_first
        // Descending scan: the last assignment is the lowest set index.
        always_comb begin
            w_idx = '0;
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (pending[i]) w_idx = IDX_W'(i);
            end
        end
    end else begin : g_highest_first
        always_comb begin
            w_idx = '0;
            for (int i = 0; i < WIDTH; i++) begin
                if (pending[i]) w_idx = IDX_W'(i);
            end
        end
    end

    assign valid  = |pending;
    assign index  = w_idx;
    assign onehot = valid ? (WIDTH'(1) << w_idx) : '0;

endmodule
`default_nettype wire

// File: rtl/match_walker.sv
`default_nettype none
// ============================================================================
//  match_walker
//  Walks a CAM match vector, emitting every hit index one beat at a time.
//  Revision: 1.0
// ============================================================================
module match_walker
    import cam_pkg::*;
#(
    parameter int    WIDTH        = 8,
    parameter string LSB_PRIORITY = PRIO_LOW,
    parameter int    IDX_W        = idx_width(WIDTH),
    parameter int    CNT_W        = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_match,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_hit,
    output logic [IDX_W-1:0] out_index,
    output logic             out_last,
    output logic [CNT_W-1:0] out_count
);

    walk_state_e      r_state;
    logic [WIDTH-1:0] r_pending;
    logic [CNT_W-1:0] r_ordinal;

    logic             w_enc_valid;
    logic [IDX_W-1:0] w_enc_idx;
    logic [WIDTH-1:0] w_enc_onehot;
    logic             w_walk;
    logic             w_single;

    match_prio_enc #(
        .WIDTH        (WIDTH),
        .LSB_PRIORITY (LSB_PRIORITY),
        .IDX_W        (IDX_W)
    ) u_enc (
        .pending (r_pending),
        .valid   (w_enc_valid),
        .index   (w_enc_idx),
        .onehot  (w_enc_onehot)
    );

    assign w_walk   = (r_state == WALK);
    // Zero or one bit left means this beat closes the transaction.
    assign w_single = ((r_pending & (r_pending - WIDTH'(1))) == '0);

    assign in_ready  = (r_state == IDLE);
    assign out_valid = w_walk;
    assign out_hit   = w_walk & w_enc_valid;
    assign out_index = w_walk ? w_enc_idx : '0;
    assign out_last  = w_walk & w_single;
    assign out_count = out_hit ? r_ordinal : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_pending <= '0;
            r_ordinal <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_pending <= in_match;
                        r_ordinal <= CNT_W'(1);
                        r_state   <= WALK;
                    end
                end
                WALK: begin
                    // Abort wins over a coincident transfer.
                    if (abort) begin
                        r_pending <= '0;
                        r_state   <= IDLE;
                    end else if (out_ready) begin
                        r_pending <= r_pending & ~w_enc_onehot;
                        r_ordinal <= r_ordinal + CNT_W'(1);
                        if (w_single) r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/match_walker.md
Name: match_walker

Overview:
- Sequential multi-match resolver for the CAM match path.
- Accepts one WIDTH-bit match vector per transaction over a valid/ready handshake.
- Emits the index of every set bit, one per beat, in priority order, over a valid/ready output stream, with a last flag and a running match count.
- Sits between the CAM match-line register and the Pass-Keeper lookup/readout logic, which needs all hits, not only the winner.

Parameters:
- WIDTH, 8, number of match lines (>=1, need not be a power of two).
- LSB_PRIORITY, "LOW", "LOW" = highest set index emitted first; "HIGH" = lowest set index emitted first.
- IDX_W, (WIDTH>1 ? $clog2(WIDTH) : 1), index width (derived, do not override).
- CNT_W, $clog2(WIDTH+1), match-count width (derived).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  match vector valid.
- in_ready  output  1  block can accept a vector.
- in_match  input  WIDTH  match lines, bit i = entry i hit.
- abort  input  1  drop current transaction.
- out_valid  output  1  output beat valid.
- out_ready  input  1  consumer accepts beat.
- out_hit  output  1  1 = out_index is a real match; 0 = no-match beat.
- out_index  output  IDX_W  matched entry index.
- out_last  output  1  final beat of transaction.
- out_count  output  CNT_W  1-based ordinal of this beat's match (0 on no-match beat).

Behaviour:
- Reset (rst_n low at a clock edge):
  - state = IDLE, pending vector = 0, ordinal = 0.
  - in_ready = 1 from the first cycle after reset deasserts.
  - out_valid = 0, out_hit = 0, out_index = 0, out_last = 0, out_count = 0.
  - Reset mid-transaction discards it with no further beats.
- States: IDLE, WALK.
- IDLE:
  - in_ready = 1, out_valid = 0.
  - in_valid & in_ready: register in_match into pending, ordinal = 1, go to WALK.
  - First beat is presented the next cycle (latency 1).
- WALK:
  - in_ready = 0, out_valid = 1.
  - out_index is a combinational priority encode of pending, direction per LSB_PRIORITY.
  - out_hit = |pending, out_count = out_hit ? ordinal : 0.
  - out_last = 1 when pending has at most one bit set.
- Beat transfer (out_valid & out_ready):
  - Clear the emitted bit in pending, ordinal += 1.
  - If out_last: go to IDLE; in_ready is high the following cycle (no overlap with next vector).
- Back-pressure: while out_ready = 0, all out_* signals are held stable. No change to out_index/out_count without a transfer.
- Empty vector: exactly one beat with out_hit = 0, out_index = 0, out_count = 0, out_last = 1.
- Throughput: one beat per cycle with out_ready held high. An N-hit vector costs N+1 cycles including accept.
- abort:
  - Sampled in WALK only; ignored in IDLE.
  - Takes precedence over a same-cycle beat transfer: the beat is not counted as transferred.
  - Next state IDLE, pending cleared, out_valid low the next cycle.
- Padding: bits above WIDTH-1 in any internal power-of-two padding are zero and never emitted.
- Max ordinal is WIDTH; CNT_W holds it without wrap.

Decomposition:
- Shared package cam_pkg:
  - clog2-safe index-width function (returns 1 for WIDTH=1).
  - State enum {IDLE, WALK}.
  - Priority-mode string constants "LOW"/"HIGH".
- One combinational sub-module, match_prio_enc (WIDTH, LSB_PRIORITY):
  - pending in; valid, index and one-hot out.
  - The one-hot output is used to clear the emitted bit.
- FSM, pending register and ordinal counter live in match_walker.

Test Plan:
- WIDTH=8, LOW, in_match=8'b1001_0010, out_ready=1 -> beats idx 7,4,1; count 1,2,3; last on third; in_ready high the cycle after.
- Same vector with HIGH -> idx 1,4,7; count 1,2,3.
- in_match=0 -> single beat hit=0 idx=0 count=0 last=1, then IDLE.
- in_match=8'hFF, out_ready toggling 1,0,0,1... -> outputs frozen during stalls; 8 beats idx 7..0, count reaches 8, no skipped or duplicated index.
- Abort and reset mid-walk:
  - in_match=8'b0110_0000, abort asserted on first beat with out_ready=1 -> no further beats, in_ready=1 next cycle.
  - Separately, rst_n low on second beat -> all outputs 0 the next cycle.
- WIDTH=5 and WIDTH=1:
  - WIDTH=5, in_match=5'b10001 -> idx 4,0.
  - WIDTH=1, in_match=1 -> one beat idx 0, count 1, last 1.
